// File: rtl/store_buffer.sv
// Store buffer: in-order write-posting FIFO with load-side lookup.
// Define STORE_BUFFER_FORWARD_EN to forward pending stores instead of flagging rd_hazard.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      st_req,
  input  logic [ADDR_W-1:0]         st_addr,
  input  logic [DATA_W-1:0]         st_data,
  output logic                      st_ready,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_waddr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_wready,
  input  logic [ADDR_W-1:0]         pc_addr,
  input  logic [ADDR_W-1:0]         data_addr,
  input  logic [DATA_W-1:0]         mem_pc_byte,
  input  logic [DATA_W-1:0]         mem_data_byte,
  output logic [2*DATA_W-1:0]       d_bus_in,
  output logic                      rd_hazard,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     wp_q, wp_d;
  logic [PW-1:0]     rp_q, rp_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic              push, pop;

  assign st_ready  = (count_q != CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign mem_we    = !empty;
  assign mem_waddr = addr_q[rp_q];
  assign mem_wdata = data_q[rp_q];
  assign count     = count_q;
  assign push      = st_req && st_ready;
  assign pop       = mem_we && mem_wready;

  always_comb begin
    wp_d    = wp_q + PW'(push);
    rp_d    = rp_q + PW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wp_q] <= st_addr;
      data_q[wp_q] <= st_data;
    end
  end

  // Scan oldest to newest so the last hit is the youngest store.
  logic          pc_hit, data_hit;
  logic [PW-1:0] idx;
`ifdef STORE_BUFFER_FORWARD_EN
  logic [DATA_W-1:0] pc_fwd, data_fwd;
`endif

  always_comb begin
    pc_hit   = 1'b0;
    data_hit = 1'b0;
    idx      = '0;
`ifdef STORE_BUFFER_FORWARD_EN
    pc_fwd   = '0;
    data_fwd = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = rp_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (addr_q[idx] == pc_addr) begin
          pc_hit = 1'b1;
`ifdef STORE_BUFFER_FORWARD_EN
          pc_fwd = data_q[idx];
`endif
        end
        if (addr_q[idx] == data_addr) begin
          data_hit = 1'b1;
`ifdef STORE_BUFFER_FORWARD_EN
          data_fwd = data_q[idx];
`endif
        end
      end
    end
  end

`ifdef STORE_BUFFER_FORWARD_EN
  assign d_bus_in  = {data_hit ? data_fwd : mem_data_byte,
                      pc_hit   ? pc_fwd   : mem_pc_byte};
  assign rd_hazard = 1'b0;
`else
  assign d_bus_in  = {mem_data_byte, mem_pc_byte};
  assign rd_hazard = pc_hit || data_hit;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: cycle vectors plus reset, wrap and lookup sequences.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_req;
  logic [15:0] st_addr;
  logic [7:0]  st_data;
  logic        st_ready;
  logic        mem_we;
  logic [15:0] mem_waddr;
  logic [7:0]  mem_wdata;
  logic        mem_wready;
  logic [15:0] pc_addr;
  logic [15:0] data_addr;
  logic [7:0]  mem_pc_byte;
  logic [7:0]  mem_data_byte;
  logic [15:0] d_bus_in;
  logic        rd_hazard;
  logic [2:0]  count;
  logic        empty;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wready(mem_wready),
    .pc_addr(pc_addr), .data_addr(data_addr),
    .mem_pc_byte(mem_pc_byte), .mem_data_byte(mem_data_byte),
    .d_bus_in(d_bus_in), .rd_hazard(rd_hazard),
    .count(count), .empty(empty)
  );

  typedef struct {
    logic        req;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        wr;
    logic        rdy;
    logic        we;
    logic [15:0] wa;
    logic [7:0]  wd;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    st_req = 1'b0;
    mem_wready = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [7:0] d);
    st_req  = 1'b1;
    st_addr = a;
    st_data = d;
    cyc();
    st_req  = 1'b0;
  endtask

  initial begin
    st_req = 0; st_addr = 0; st_data = 0; mem_wready = 0;
    pc_addr = 16'hAAAA; data_addr = 16'hBBBB;
    mem_pc_byte = 8'h5A; mem_data_byte = 8'hC3;
    rst = 1'b0;
    #2;
    chk("rst_we",    mem_we, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ready", st_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_haz",   rd_hazard, 0);
    chk("rst_dbus",  d_bus_in, 16'hC35A);
    do_reset();

    // single store, then fill/refuse, full+pop, in-order drain
    tbl.push_back('{1, 16'h0010, 8'hBA, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 16'h0000, 8'h00, 1, 1, 1, 16'h0010, 8'hBA, 1});
    tbl.push_back('{0, 16'h0000, 8'h00, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{1, 16'h0100, 8'hA0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{1, 16'h0101, 8'hA1, 0, 1, 1, 16'h0100, 8'hA0, 1});
    tbl.push_back('{1, 16'h0102, 8'hA2, 0, 1, 1, 16'h0100, 8'hA0, 2});
    tbl.push_back('{1, 16'h0103, 8'hA3, 0, 1, 1, 16'h0100, 8'hA0, 3});
    tbl.push_back('{1, 16'h0104, 8'hA4, 0, 0, 1, 16'h0100, 8'hA0, 4});
    tbl.push_back('{1, 16'h0104, 8'hA4, 1, 0, 1, 16'h0100, 8'hA0, 4});
    tbl.push_back('{1, 16'h0104, 8'hA4, 1, 1, 1, 16'h0101, 8'hA1, 3});
    tbl.push_back('{0, 16'h0000, 8'h00, 1, 1, 1, 16'h0102, 8'hA2, 3});
    tbl.push_back('{0, 16'h0000, 8'h00, 1, 1, 1, 16'h0103, 8'hA3, 2});
    tbl.push_back('{0, 16'h0000, 8'h00, 1, 1, 1, 16'h0104, 8'hA4, 1});
    tbl.push_back('{0, 16'h0000, 8'h00, 1, 1, 0, 0, 0, 0});

    foreach (tbl[i]) begin
      st_req     = tbl[i].req;
      st_addr    = tbl[i].addr;
      st_data    = tbl[i].data;
      mem_wready = tbl[i].wr;
      @(negedge clk);
      chk($sformatf("v%0d_rdy", i), st_ready, tbl[i].rdy);
      chk($sformatf("v%0d_we", i),  mem_we,   tbl[i].we);
      chk($sformatf("v%0d_cnt", i), count,    tbl[i].cnt);
      chk($sformatf("v%0d_emp", i), empty,    tbl[i].cnt == 0);
      if (tbl[i].we) begin
        chk($sformatf("v%0d_wa", i), mem_waddr, tbl[i].wa);
        chk($sformatf("v%0d_wd", i), mem_wdata, tbl[i].wd);
      end
      cyc();
    end
    st_req = 1'b0;

    // continuous push/drain across pointer wrap
    mem_wready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      st_req  = (k < 10);
      st_addr = 16'h0200 + 16'(k);
      st_data = 8'h50 + 8'(k);
      @(negedge clk);
      if (k == 0) begin
        chk("wrap_cnt0", count, 0);
      end else begin
        chk($sformatf("wrap%0d_cnt", k), count, 1);
        chk($sformatf("wrap%0d_wa", k), mem_waddr, 16'h0200 + 16'(k - 1));
        chk($sformatf("wrap%0d_wd", k), mem_wdata, 8'h50 + 8'(k - 1));
      end
      cyc();
    end
    st_req = 1'b0;
    @(negedge clk);
    chk("wrap_end_cnt", count, 0);
    cyc();

    // lookup: two stores to 0xFFFF, one to 0x0020
    mem_wready = 1'b0;
    data_addr = 16'hFFFF;
    mem_data_byte = 8'h00;
    pc_addr = 16'h0020;
    mem_pc_byte = 8'h77;
    st_req = 1'b1; st_addr = 16'hFFFF; st_data = 8'h11;
    #1;
    chk("fwd_nopush", d_bus_in, 16'h0077);
    cyc();
    push(16'hFFFF, 8'h22);
    push(16'h0020, 8'h33);
    #1;
`ifdef STORE_BUFFER_FORWARD_EN
    chk("fwd_dbus", d_bus_in, 16'h2233);
    chk("fwd_haz",  rd_hazard, 0);
`else
    chk("nofwd_dbus", d_bus_in, 16'h0077);
    chk("nofwd_haz",  rd_hazard, 1);
`endif
    pc_addr = 16'h0021;
    data_addr = 16'h0021;
    #1;
    chk("miss_dbus", d_bus_in, 16'h0077);
    chk("miss_haz",  rd_hazard, 0);

    // asynchronous reset with entries pending
    @(negedge clk);
    chk("pre_rst_cnt", count, 3);
    chk("pre_rst_we",  mem_we, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_we",  mem_we, 0);
    chk("mid_rst_cnt", count, 0);
    chk("mid_rst_emp", empty, 1);
    @(negedge clk);
    rst = 1'b1;
    mem_wready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_we", k), mem_we, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
